// File: rtl/ball_motion_if.sv
// rtl/ball_motion_if.sv - scan position, paddle and ball status bundle for ball_motion
// The master side drives scan/paddle inputs; the slave side is the ball engine.
interface ball_motion_if;
  logic [9:0] i_row;
  logic [9:0] i_col;
  logic       i_run;
  logic [9:0] i_pad_l_y;
  logic [9:0] i_pad_r_y;
  logic [9:0] o_ball_x;
  logic [9:0] o_ball_y;
  logic       o_ball_present;
  logic       o_point_l;
  logic       o_point_r;
  logic       o_serving;

  modport master (
    output i_row, i_col, i_run, i_pad_l_y, i_pad_r_y,
    input  o_ball_x, o_ball_y, o_ball_present, o_point_l, o_point_r, o_serving
  );

  modport slave (
    input  i_row, i_col, i_run, i_pad_l_y, i_pad_r_y,
    output o_ball_x, o_ball_y, o_ball_present, o_point_l, o_point_r, o_serving
  );
endinterface

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - pong ball engine: serve timing, wall/paddle bounce, scoring, pixel hit
// Position advances once per frame on the synchronised (V_ACTIVE, 0) scan entry while run is high.
module ball_motion #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int SPEED        = 2,
  parameter int PAD_H        = 64,
  parameter int PAD_W        = 8,
  parameter int PAD_XL       = 16,
  parameter int PAD_XR       = 616,
  parameter int SERVE_FRAMES = 60
) (
  input  logic          clk,
  input  logic          rst_n,
  ball_motion_if.slave  bus
);

  localparam logic [10:0] CX     = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] CY     = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] SPD    = 11'(SPEED);
  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] PH     = 11'(PAD_H);
  localparam logic [10:0] L_EDGE = 11'(PAD_XL + PAD_W);
  localparam logic [10:0] R_EDGE = 11'(PAD_XR);
  localparam logic [10:0] R_STOP = 11'(PAD_XR - BALL_SIZE);
  localparam logic [15:0] SERVE_LAST = 16'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_SCORED} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [9:0]  r_row_s1, r_row_s2;
  logic [9:0]  r_col_s1, r_col_s2;
  logic        r_at_prev;
  logic [15:0] r_serve_cnt;
  logic [9:0]  r_x, r_y;
  logic        r_dx, r_dy;
  logic        r_scorer_r;
  logic        r_point_l, r_point_r;
  logic        r_present;

  logic        w_at, w_tick, w_upd;
  logic [10:0] w_x, w_y, w_pl, w_pr;
  logic        w_ovl_l, w_ovl_r;
  logic [9:0]  w_x_nxt, w_y_nxt;
  logic        w_dx_nxt, w_dy_nxt;
  logic        w_out_left, w_out_right;
  logic        w_serve_upd, w_play_upd, w_scored_upd;
  logic        w_score_l, w_score_r;
  logic        w_serving;
  logic        w_hit_x, w_hit_y;

  // Scan position comes from a slower pixel domain; double-flop before any use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1  <= '0;
      r_row_s2  <= '0;
      r_col_s1  <= '0;
      r_col_s2  <= '0;
      r_at_prev <= 1'b0;
    end else begin
      r_row_s1  <= bus.i_row;
      r_row_s2  <= r_row_s1;
      r_col_s1  <= bus.i_col;
      r_col_s2  <= r_col_s1;
      r_at_prev <= w_at;
    end
  end

  assign w_at   = (r_row_s2 == 10'(V_ACTIVE)) && (r_col_s2 == 10'd0);
  assign w_tick = w_at && !r_at_prev;
  assign w_upd  = w_tick && bus.i_run;

  assign w_x  = {1'b0, r_x};
  assign w_y  = {1'b0, r_y};
  assign w_pl = {1'b0, bus.i_pad_l_y};
  assign w_pr = {1'b0, bus.i_pad_r_y};

  assign w_ovl_l = (w_y + BS > w_pl) && (w_y < w_pl + PH);
  assign w_ovl_r = (w_y + BS > w_pr) && (w_y < w_pr + PH);

  always_comb begin
    w_y_nxt  = r_y;
    w_dy_nxt = r_dy;
    if (!r_dy) begin
      if (w_y < SPD) begin
        w_y_nxt  = '0;
        w_dy_nxt = 1'b1;
      end else begin
        w_y_nxt  = 10'(w_y - SPD);
      end
    end else begin
      if (w_y + SPD > Y_MAX) begin
        w_y_nxt  = 10'(Y_MAX);
        w_dy_nxt = 1'b0;
      end else begin
        w_y_nxt  = 10'(w_y + SPD);
      end
    end
  end

  // A paddle hit is tested before the miss so a ball clamped onto a paddle never scores.
  always_comb begin
    w_x_nxt     = r_x;
    w_dx_nxt    = r_dx;
    w_out_left  = 1'b0;
    w_out_right = 1'b0;
    if (!r_dx) begin
      if ((w_x < L_EDGE + SPD) && (w_x >= L_EDGE) && w_ovl_l) begin
        w_x_nxt  = 10'(L_EDGE);
        w_dx_nxt = 1'b1;
      end else if (w_x < SPD) begin
        w_out_left = 1'b1;
      end else begin
        w_x_nxt  = 10'(w_x - SPD);
      end
    end else begin
      if ((w_x + BS + SPD > R_EDGE) && (w_x + BS <= R_EDGE) && w_ovl_r) begin
        w_x_nxt  = 10'(R_STOP);
        w_dx_nxt = 1'b0;
      end else if (w_x + SPD > X_MAX) begin
        w_out_right = 1'b1;
      end else begin
        w_x_nxt  = 10'(w_x + SPD);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SERVE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_upd) begin
      case (r_state)
        ST_SERVE:  if (r_serve_cnt == SERVE_LAST) w_state_nxt = ST_PLAY;
        ST_PLAY:   if (w_out_left || w_out_right) w_state_nxt = ST_SCORED;
        ST_SCORED: w_state_nxt = ST_SERVE;
        default:   w_state_nxt = ST_SERVE;
      endcase
    end
  end

  always_comb begin
    w_serving    = (r_state == ST_SERVE);
    w_serve_upd  = w_upd && (r_state == ST_SERVE);
    w_play_upd   = w_upd && (r_state == ST_PLAY);
    w_scored_upd = w_upd && (r_state == ST_SCORED);
    w_score_l    = w_play_upd && w_out_right;
    w_score_r    = w_play_upd && w_out_left;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_serve_cnt <= '0;
      r_x         <= 10'(CX);
      r_y         <= 10'(CY);
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_scorer_r  <= 1'b0;
      r_point_l   <= 1'b0;
      r_point_r   <= 1'b0;
    end else begin
      r_point_l <= w_score_l;
      r_point_r <= w_score_r;
      if (w_serve_upd) begin
        r_x         <= 10'(CX);
        r_y         <= 10'(CY);
        r_serve_cnt <= r_serve_cnt + 16'd1;
      end
      if (w_play_upd) begin
        r_x  <= w_x_nxt;
        r_y  <= w_y_nxt;
        r_dx <= w_dx_nxt;
        r_dy <= w_dy_nxt;
        if (w_out_left || w_out_right) r_scorer_r <= w_out_left;
      end
      // Serve toward the player who just conceded; dy carries over.
      if (w_scored_upd) begin
        r_x         <= 10'(CX);
        r_y         <= 10'(CY);
        r_dx        <= !r_scorer_r;
        r_serve_cnt <= '0;
      end
    end
  end

  assign w_hit_x = ({1'b0, r_col_s2} - w_x) < BS;
  assign w_hit_y = ({1'b0, r_row_s2} - w_y) < BS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_present <= 1'b0;
    end else begin
      r_present <= w_hit_x && w_hit_y;
    end
  end

  assign bus.o_ball_x       = r_x;
  assign bus.o_ball_y       = r_y;
  assign bus.o_ball_present = r_present;
  assign bus.o_point_l      = r_point_l;
  assign bus.o_point_r      = r_point_r;
  assign bus.o_serving      = w_serving;

endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - randomized frame stimulus against a game-rule model with a scoreboard
// Stimulus pushes expected post-frame state; a monitor pops and compares at the stamped cycle.
module tb_ball_motion;

  localparam int H = 640, V = 480, BS = 8, SP = 2, PH = 64, PW = 8;
  localparam int PXL = 16, PXR = 616, SF = 60;
  localparam int CX = (H - BS) / 2, CY = (V - BS) / 2;
  localparam int NFRAMES = 1400;

  typedef struct {
    int stamp;
    int x;
    int y;
    int srv;
    int pl;
    int pr;
    int pres;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ball_motion_if bus ();

  ball_motion dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pl_seen = 0;
  int pr_seen = 0;

  // game-rule model: 0 = serving, 1 = in play, 2 = point just scored
  int mx, my, mdx, mdy, mst, mcnt, mscr_r, epl, epr;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.o_point_l) pl_seen++;
      if (bus.o_point_r) pr_seen++;
    end
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      e = q.pop_front();
      chk("ball_x", int'(bus.o_ball_x), e.x);
      chk("ball_y", int'(bus.o_ball_y), e.y);
      chk("serving", int'(bus.o_serving), e.srv);
      chk("point_l_pulses", pl_seen, e.pl);
      chk("point_r_pulses", pr_seen, e.pr);
      chk("ball_present", int'(bus.o_ball_present), e.pres);
    end
  end

  task automatic model_tick(input int pl_y, input int pr_y);
    int ny, ndy, nx, ndx;
    bit hit_l, hit_r;
    case (mst)
      0: begin
        mx = CX;
        my = CY;
        if (mcnt == SF - 1) mst = 1;
        else mcnt++;
      end
      1: begin
        ndy = mdy;
        if (mdy == 0) begin
          if (my < SP) begin ny = 0; ndy = 1; end
          else ny = my - SP;
        end else begin
          if (my + SP > V - BS) begin ny = V - BS; ndy = 0; end
          else ny = my + SP;
        end
        nx = mx;
        ndx = mdx;
        hit_l = (mx - SP < PXL + PW) && (mx >= PXL + PW) && (my + BS > pl_y) && (my < pl_y + PH);
        hit_r = (mx + BS + SP > PXR) && (mx + BS <= PXR) && (my + BS > pr_y) && (my < pr_y + PH);
        if (mdx == 0) begin
          if (hit_l) begin nx = PXL + PW; ndx = 1; end
          else if (mx < SP) begin mst = 2; mscr_r = 1; epr++; end
          else nx = mx - SP;
        end else begin
          if (hit_r) begin nx = PXR - BS; ndx = 0; end
          else if (mx + SP > H - BS) begin mst = 2; mscr_r = 0; epl++; end
          else nx = mx + SP;
        end
        mx = nx;
        my = ny;
        mdx = ndx;
        mdy = ndy;
      end
      default: begin
        mst = 0;
        mcnt = 0;
        mx = CX;
        my = CY;
        mdx = mscr_r ? 0 : 1;
      end
    endcase
  endtask

  function automatic int pick_pad(input int by);
    int p;
    if ($urandom_range(1) == 1) begin
      p = by - int'($urandom_range(0, 60));
      if (p < 0) p = 0;
    end else begin
      p = int'($urandom_range(0, V - PH));
    end
    return p;
  endfunction

  initial begin
    int run, pl_y, pr_y, hold, r, c, pres, waited;
    bus.i_row = '0;
    bus.i_col = '0;
    bus.i_run = 1'b0;
    bus.i_pad_l_y = '0;
    bus.i_pad_r_y = '0;
    repeat (3) @(negedge clk);
    chk("reset_ball_x", int'(bus.o_ball_x), CX);
    chk("reset_ball_y", int'(bus.o_ball_y), CY);
    chk("reset_serving", int'(bus.o_serving), 1);
    chk("reset_point_l", int'(bus.o_point_l), 0);
    chk("reset_point_r", int'(bus.o_point_r), 0);
    chk("reset_present", int'(bus.o_ball_present), 0);
    rst_n = 1'b1;
    mx = CX; my = CY; mdx = 1; mdy = 1; mst = 0; mcnt = 0; mscr_r = 0; epl = 0; epr = 0;
    repeat (3) @(negedge clk);

    for (int f = 0; f < NFRAMES; f++) begin
      run  = (f < 61) ? 1 : int'($urandom_range(7) != 0);
      pl_y = pick_pad(my);
      pr_y = pick_pad(my);
      hold = ($urandom_range(19) == 0) ? 100 : int'($urandom_range(3, 5));
      bus.i_run     = run[0];
      bus.i_pad_l_y = 10'(pl_y);
      bus.i_pad_r_y = 10'(pr_y);
      bus.i_row     = 10'(V);
      bus.i_col     = 10'd0;
      repeat (hold) @(negedge clk);
      if (run != 0) model_tick(pl_y, pr_y);
      r = (my + int'($urandom_range(0, 15)) - 4) & 1023;
      c = (mx + int'($urandom_range(0, 15)) - 4) & 1023;
      if (r == V && c == 0) c = 1;
      bus.i_row = 10'(r);
      bus.i_col = 10'(c);
      repeat (6) @(negedge clk);
      pres = (c >= mx && c < mx + BS && r >= my && r < my + BS) ? 1 : 0;
      q.push_back('{stamp: cyc + 1, x: mx, y: my, srv: (mst == 0) ? 1 : 0,
                    pl: epl, pr: epr, pres: pres});
    end

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() > 0) chk("scoreboard_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
